regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_regwb_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwb_arbiter.sv
// -----------------------------------------------------------------------------
// regwb_arbiter
//
// Purpose:
//   Merges register-file writebacks from three sources onto one registered
//   write port:
//     * requester A (ALU writeback), queued in a DEPTH-entry FIFO
//     * requester B (multicycle / load unit), queued in a DEPTH-entry FIFO
//     * a one-cycle overflow-status update, held in a single pending bit and
//       written to register 30
//   A pending overflow update always wins. A and B share the port
//   round-robin.
//   Writes to register 0 are accepted and dropped.
//
// Parameters:
//   DEPTH      entries per requester queue (power of two, >= 2)
//
// Ports:
//   clk        single clock, rising-edge
//   rst        asynchronous, active-high reset
//   a_valid    A has a write this cycle
//   a_ready    A queue is not full (depends only on registered occupancy)
//   a_reg      A destination register
//   a_data     A write data
//   b_*        same as a_*, for requester B
//   ovf_valid  one-cycle overflow-status update request
//   ovf_flag   overflow value to record in register 30
//   regwrite   register-file write enable (registered, one cycle per write)
//   wrreg      register-file write address (registered, held when idle)
//   wrdata     register-file write data (registered, held when idle)
//   busy       a queue entry or overflow update is pending, or regwrite is high
// -----------------------------------------------------------------------------
module regwb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,

    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,

    input  logic        ovf_valid,
    input  logic        ovf_flag,

    output logic        regwrite,
    output logic [4:0]  wrreg,
    output logic [31:0] wrdata,
    output logic        busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [4:0] OVF_REG = 5'd30;

    // Requester index 0 is A, index 1 is B.
    logic [1:0]        in_valid;
    logic [1:0][4:0]   in_reg;
    logic [1:0][31:0]  in_data;
    logic [1:0]        q_ready;
    logic [1:0]        q_nonempty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0][4:0]   head_reg;
    logic [1:0][31:0]  head_data;

    assign in_valid = {b_valid, a_valid};
    assign in_reg   = {b_reg, a_reg};
    assign in_data  = {b_data, a_data};

    // -------------------------------------------------------------------------
    // Per-requester FIFOs
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_queue
            logic [4:0]    reg_mem  [DEPTH];
            logic [31:0]   data_mem [DEPTH];
            logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
            logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
            logic [CW-1:0] count_reg, count_next;

            // Ready looks only at registered occupancy, so a full queue never
            // accepts even if it is being popped in the same cycle.
            assign q_ready[gi]    = (count_reg != CW'(DEPTH));
            assign q_nonempty[gi] = (count_reg != '0);

            // Register-0 writes complete the handshake but are never stored.
            assign push[gi] = in_valid[gi] && q_ready[gi] && (in_reg[gi] != 5'd0);

            assign head_reg[gi]  = reg_mem[rd_ptr_reg];
            assign head_data[gi] = data_mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    reg_mem[wr_ptr_reg]  <= in_reg[gi];
                    data_mem[wr_ptr_reg] <= in_data[gi];
                end
            end

            // DEPTH is a power of two, so the pointers wrap by plain overflow.
            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                count_next  = count_reg;
                if (push[gi]) begin
                    wr_ptr_next = wr_ptr_reg + PW'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_next = rd_ptr_reg + PW'(1);
                end
                case ({push[gi], pop[gi]})
                    2'b10:   count_next = count_reg + CW'(1);
                    2'b01:   count_next = count_reg - CW'(1);
                    default: count_next = count_reg;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    count_reg  <= count_next;
                end
            end
        end
    endgenerate

    assign a_ready = q_ready[0];
    assign b_ready = q_ready[1];

    // -------------------------------------------------------------------------
    // Overflow pending bit and round-robin pointer
    // -------------------------------------------------------------------------
    logic ovf_pend_reg, ovf_pend_next;
    logic ovf_flag_reg, ovf_flag_next;
    // last_a_reg = 1 means A was granted last, so B is preferred when both
    // queues hold entries. Reset value 0 prefers A first.
    logic last_a_reg, last_a_next;
    logic grant_ovf, grant_a, grant_b;

    always_comb begin
        grant_ovf = ovf_pend_reg;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        if (!ovf_pend_reg) begin
            if (q_nonempty[0] && q_nonempty[1]) begin
                grant_a = !last_a_reg;
                grant_b = last_a_reg;
            end else begin
                grant_a = q_nonempty[0];
                grant_b = q_nonempty[1];
            end
        end
    end

    assign pop = {grant_b, grant_a};

    always_comb begin
        ovf_pend_next = ovf_pend_reg;
        ovf_flag_next = ovf_flag_reg;
        last_a_next   = last_a_reg;
        // A new request takes precedence over the clear, so a request that
        // lands on the cycle the old one is written is not lost.
        if (ovf_valid) begin
            ovf_pend_next = 1'b1;
            ovf_flag_next = ovf_flag;
        end else if (grant_ovf) begin
            ovf_pend_next = 1'b0;
        end
        if (grant_a) begin
            last_a_next = 1'b1;
        end else if (grant_b) begin
            last_a_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_pend_reg <= 1'b0;
            ovf_flag_reg <= 1'b0;
            last_a_reg   <= 1'b0;
        end else begin
            ovf_pend_reg <= ovf_pend_next;
            ovf_flag_reg <= ovf_flag_next;
            last_a_reg   <= last_a_next;
        end
    end

    // -------------------------------------------------------------------------
    // Registered write port
    // -------------------------------------------------------------------------
    logic        regwrite_reg, regwrite_next;
    logic [4:0]  wrreg_reg, wrreg_next;
    logic [31:0] wrdata_reg, wrdata_next;

    always_comb begin
        regwrite_next = 1'b0;
        wrreg_next    = wrreg_reg;
        wrdata_next   = wrdata_reg;
        if (grant_ovf) begin
            regwrite_next = 1'b1;
            wrreg_next    = OVF_REG;
            wrdata_next   = {31'b0, ovf_flag_reg};
        end else if (grant_a) begin
            regwrite_next = 1'b1;
            wrreg_next    = head_reg[0];
            wrdata_next   = head_data[0];
        end else if (grant_b) begin
            regwrite_next = 1'b1;
            wrreg_next    = head_reg[1];
            wrdata_next   = head_data[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_reg <= 1'b0;
            wrreg_reg    <= '0;
            wrdata_reg   <= '0;
        end else begin
            regwrite_reg <= regwrite_next;
            wrreg_reg    <= wrreg_next;
            wrdata_reg   <= wrdata_next;
        end
    end

    assign regwrite = regwrite_reg;
    assign wrreg    = wrreg_reg;
    assign wrdata   = wrdata_reg;
    assign busy     = (|q_nonempty) | ovf_pend_reg | regwrite_reg;

endmodule

// File: tb/tb_regwb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regwb_arbiter
//
// Purpose:
//   Self-checking bench for regwb_arbiter. A queue-based reference model,
//   stepped once per clock edge, predicts every output. Directed scenarios
//   also compare against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_regwb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, ovf_valid, ovf_flag;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        regwrite, busy;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;

    int checks = 0;
    int errors = 0;

    regwb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .ovf_valid(ovf_valid), .ovf_flag(ovf_flag),
        .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    entry_t      qa[$];
    entry_t      qb[$];
    bit          m_pend, m_flag, m_last_a, m_regwrite;
    logic [4:0]  m_wrreg;
    logic [31:0] m_wrdata;

    function automatic void model_clear();
        qa.delete();
        qb.delete();
        m_pend = 0; m_flag = 0; m_last_a = 0; m_regwrite = 0;
        m_wrreg = '0; m_wrdata = '0;
    endfunction

    function automatic logic [40:0] model_out();
        logic m_busy;
        m_busy = (qa.size() != 0) || (qb.size() != 0) || m_pend || m_regwrite;
        return {m_regwrite, m_wrreg, m_wrdata, m_busy,
                logic'(qa.size() < DEPTH), logic'(qb.size() < DEPTH)};
    endfunction

    function automatic logic [40:0] dut_out();
        return {regwrite, wrreg, wrdata, busy, a_ready, b_ready};
    endfunction

    // Advance one clock edge, updating the model from the inputs seen just
    // before the edge. Outputs are ready to sample when this returns.
    task automatic tick();
        bit acc_a, acc_b, go, ga, gb, ov, of;
        entry_t ea, eb, e;
        int na, nb;
        na = qa.size();
        nb = qb.size();
        acc_a = a_valid && (na < DEPTH) && (a_reg != 5'd0);
        acc_b = b_valid && (nb < DEPTH) && (b_reg != 5'd0);
        ea = {a_reg, a_data};
        eb = {b_reg, b_data};
        ov = ovf_valid;
        of = ovf_flag;
        go = m_pend;
        ga = !go && (na > 0) && ((nb == 0) || !m_last_a);
        gb = !go && (nb > 0) && ((na == 0) || m_last_a);
        @(posedge clk);
        #1;
        m_regwrite = go || ga || gb;
        if (go) begin
            m_wrreg = 5'd30; m_wrdata = {31'b0, m_flag};
        end else if (ga) begin
            e = qa.pop_front(); m_wrreg = e.r; m_wrdata = e.d; m_last_a = 1;
        end else if (gb) begin
            e = qb.pop_front(); m_wrreg = e.r; m_wrdata = e.d; m_last_a = 0;
        end
        if (ov) begin
            m_pend = 1; m_flag = of;
        end else if (go) begin
            m_pend = 0;
        end
        if (acc_a) qa.push_back(ea);
        if (acc_b) qb.push_back(eb);
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; ovf_valid = 0; ovf_flag = 0;
        a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    endtask

    // Idle until the model is quiet, comparing every cycle.
    task automatic drain(input string name);
        int n = 0;
        idle_inputs();
        while ((qa.size() != 0 || qb.size() != 0 || m_pend || m_regwrite) && n < 30) begin
            tick();
            n++;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL %s drain: got %h want %h", name, dut_out(), model_out());
            end
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL %s drain timeout: got busy=%0b want 0", name, busy);
        end
    endtask

    // Assert rst a little after an edge, check the immediate effect, hold it
    // across one edge and release it.
    task automatic do_reset(input string name);
        rst = 1;
        #1;
        checks++;
        if ({regwrite, wrreg, wrdata, busy, a_ready, b_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL %s reset: got rw=%0b reg=%0d data=%h busy=%0b ar=%0b br=%0b want 0 0 0 0 1 1",
                     name, regwrite, wrreg, wrdata, busy, a_ready, b_ready);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst = 0;
        $display("reset %s done", name);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1;
        model_clear();
        #2;
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_out(), model_out());
        end
        @(posedge clk);
        #1;
        rst = 0;
        $display("test_reset: outputs %h", dut_out());
    endtask

    task automatic test_single();
        idle_inputs();
        a_valid = 1; a_reg = 5; a_data = 32'h11;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_inputs();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL single cyc%0d: got %h want %h", i, dut_out(), model_out());
            end
            // Hand-derived: write appears after the second edge only.
            checks++;
            if (regwrite !== (i == 1)) begin
                errors++;
                $display("FAIL single_rw cyc%0d: got %0b want %0b", i, regwrite, (i == 1));
            end
            if (i == 1) begin
                checks++;
                if (wrreg !== 5'd5 || wrdata !== 32'h11) begin
                    errors++;
                    $display("FAIL single_data: got reg=%0d data=%h want 5 11", wrreg, wrdata);
                end
            end
            $display("single cyc%0d rw=%0b reg=%0d data=%h busy=%0b", i, regwrite, wrreg, wrdata, busy);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %0b want 0", busy);
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        a_valid = 1; a_reg = 0; a_data = 32'hFFFF;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) idle_inputs();
            tick();
            checks++;
            if (regwrite !== 1'b0 || busy !== 1'b0 || dut_out() !== model_out()) begin
                errors++;
                $display("FAIL zero_reg cyc%0d: got %h want %h", i, dut_out(), model_out());
            end
            $display("zero_reg cyc%0d rw=%0b busy=%0b", i, regwrite, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_reg [2] = '{5'd3, 5'd4};
        do_reset("rr");
        a_valid = 1; a_reg = 3; a_data = 32'hA;
        b_valid = 1; b_reg = 4; b_data = 32'hB;
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (regwrite !== 1'b1 || wrreg !== exp_reg[i] || dut_out() !== model_out()) begin
                errors++;
                $display("FAIL rr write%0d: got rw=%0b reg=%0d want 1 %0d", i, regwrite, wrreg, exp_reg[i]);
            end
            $display("rr write%0d reg=%0d data=%h", i, wrreg, wrdata);
        end
        // Second pair: order follows the pointer left by the first pair.
        a_valid = 1; a_reg = 3; a_data = 32'hA;
        b_valid = 1; b_reg = 4; b_data = 32'hB;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL rr repeat cyc%0d: got %h want %h", i, dut_out(), model_out());
            end
            $display("rr repeat cyc%0d rw=%0b reg=%0d", i, regwrite, wrreg);
        end
        drain("rr");
    endtask

    task automatic test_ovf();
        ovf_valid = 1; ovf_flag = 1;
        a_valid = 1; a_reg = 7; a_data = 32'h7;
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (regwrite !== 1'b1 || wrreg !== (i == 0 ? 5'd30 : 5'd7) || wrdata !== (i == 0 ? 32'h1 : 32'h7)) begin
                errors++;
                $display("FAIL ovf write%0d: got reg=%0d data=%h want %0d %h", i, wrreg, wrdata,
                         (i == 0 ? 30 : 7), (i == 0 ? 32'h1 : 32'h7));
            end
            $display("ovf write%0d reg=%0d data=%h", i, wrreg, wrdata);
        end
        // Back-to-back requests: the second re-arms the bit as it clears.
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            if (i < 2) begin ovf_valid = 1; ovf_flag = (i == 0); end
            if (i == 0) begin ovf_valid = 1; ovf_flag = 1; end
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL ovf b2b cyc%0d: got %h want %h", i, dut_out(), model_out());
            end
            $display("ovf b2b cyc%0d rw=%0b reg=%0d data=%h", i, regwrite, wrreg, wrdata);
        end
        drain("ovf");
    endtask

    task automatic test_backpressure();
        logic [31:0] a_log[$];
        int  idx = 0;
        bit  saw_full = 0;
        idle_inputs();
        for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
            a_valid = 1; a_reg = 5'(8 + idx); a_data = 32'hA0 + idx;
            b_valid = 1; b_reg = 20; b_data = $urandom;
            if (!a_ready) saw_full = 1;
            if (qa.size() < DEPTH) idx++;
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL backpressure cyc%0d: got %h want %h", cyc, dut_out(), model_out());
            end
            if (regwrite && wrreg >= 8 && wrreg <= 11) a_log.push_back(wrdata);
            $display("bp cyc%0d ar=%0b br=%0b rw=%0b reg=%0d data=%h", cyc, a_ready, b_ready, regwrite, wrreg, wrdata);
        end
        idle_inputs();
        for (int n = 0; n < 30 && (qa.size() != 0 || qb.size() != 0 || m_regwrite); n++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL backpressure drain%0d: got %h want %h", n, dut_out(), model_out());
            end
            if (regwrite && wrreg >= 8 && wrreg <= 11) a_log.push_back(wrdata);
        end
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("FAIL backpressure a_ready_low: got %0b want 1", saw_full);
        end
        checks++;
        if (a_log.size() != 4) begin
            errors++;
            $display("FAIL backpressure count: got %0d want 4", a_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (a_log[i] !== 32'hA0 + i) begin
                    errors++;
                    $display("FAIL backpressure order%0d: got %h want %h", i, a_log[i], 32'hA0 + i);
                end
            end
        end
        drain("bp");
    endtask

    task automatic test_random();
        int bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            a_valid   = ($urandom_range(0, 3) != 0);
            a_reg     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a_data    = $urandom;
            b_valid   = ($urandom_range(0, 1) != 0);
            b_reg     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            b_data    = $urandom;
            ovf_valid = ($urandom_range(0, 7) == 0);
            ovf_flag  = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random cyc%0d: got %h want %h", cyc, dut_out(), model_out());
            end
            if (cyc % 50 == 0)
                $display("random cyc%0d rw=%0b reg=%0d data=%h busy=%0b", cyc, regwrite, wrreg, wrdata, busy);
        end
        drain("random");
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; a_reg = 5'(12 + i); a_data = $urandom;
            b_valid = 1; b_reg = 5'(16 + i); b_data = $urandom;
            ovf_valid = (i == 2); ovf_flag = 1;
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL mid_reset fill%0d: got %h want %h", i, dut_out(), model_out());
            end
        end
        idle_inputs();
        do_reset("mid");
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (regwrite !== 1'b0 || busy !== 1'b0 || dut_out() !== model_out()) begin
                errors++;
                $display("FAIL mid_reset after%0d: got rw=%0b busy=%0b want 0 0", i, regwrite, busy);
            end
        end
        // First edge after release must accept a transfer.
        a_valid = 1; a_reg = 9; a_data = 32'h99;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (regwrite !== 1'b1 || wrreg !== 5'd9 || wrdata !== 32'h99) begin
            errors++;
            $display("FAIL mid_reset first: got rw=%0b reg=%0d data=%h want 1 9 99", regwrite, wrreg, wrdata);
        end
        $display("mid_reset first write rw=%0b reg=%0d data=%h", regwrite, wrreg, wrdata);
        drain("mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_reg();
        test_round_robin();
        test_ovf();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
